ddfs_sample_decimator: RTL

//   Downstream consumer of the DDFS waveform outputs (Sine_out / Tri_out). Averages DECIM consecutive

---
 rtl/ddfs_pkg.sv | 26 ++
 rtl/ddfs_sync_fifo.sv | 54 +++++
 rtl/ddfs_sample_decimator.sv | 97 +++++++++
 3 files changed

// File: rtl/ddfs_pkg.sv
// Shared DDFS constants and width helpers used by the synthesizer and its downstream stages.
package ddfs_pkg;

    localparam int DDFS_SAMPLE_W = 16;
    localparam int DDFS_TRI_W    = 17;

    typedef int unsigned ddfs_width_t;

    function automatic ddfs_width_t clog2(input ddfs_width_t value);
        ddfs_width_t r;
        ddfs_width_t v;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Sum of 2**log2_decim samples of data_w bits never exceeds data_w+log2_decim signed bits.
    function automatic ddfs_width_t acc_width(input ddfs_width_t data_w, input ddfs_width_t log2_decim);
        return data_w + log2_decim;
    endfunction

endpackage

// File: rtl/ddfs_sync_fifo.sv
// First-word-fall-through synchronous FIFO with extra-bit pointers; a push while full
// is taken only when a pop frees the head slot on the same edge.
module ddfs_sync_fifo
    import ddfs_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int PTR_W = int'(clog2(DEPTH))
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (PTR_W+1)'(DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rd_ptr[PTR_W-1:0]];

    // Storage is cleared too so the head reads zero after reset or clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[PTR_W-1:0]] <= wdata;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ddfs_sample_decimator.sv
// Averages 2**LOG2_DECIM valid DDFS samples into one output buffered in a FWFT FIFO.
// Define DDFS_DECIM_ROUND_EN for round-half-up instead of floor on the averaged result.
module ddfs_sample_decimator
    import ddfs_pkg::*;
#(
    parameter  int DATA_W     = DDFS_SAMPLE_W,
    parameter  int LOG2_DECIM = 3,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = int'(clog2(FIFO_DEPTH)) + 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LVL_W-1:0]         fifo_level,
    output logic                     overflow
);

    localparam int ACC_W = int'(acc_width(DATA_W, LOG2_DECIM));
    localparam int DECIM = 1 << LOG2_DECIM;

    logic signed [ACC_W-1:0]      acc;
    logic        [LOG2_DECIM-1:0] cnt;
    logic signed [ACC_W-1:0]      sample_ext;
    logic signed [ACC_W-1:0]      sum;
    logic signed [ACC_W-1:0]      rsum;
    logic        [DATA_W-1:0]     result;
    logic                         unused_lsbs;
    logic                         last;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         empty;
    logic        [DATA_W-1:0]     head;

    assign sample_ext = ACC_W'(in_data);
    assign sum        = acc + sample_ext;

`ifdef DDFS_DECIM_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1 << (LOG2_DECIM - 1));
    assign rsum = sum + RND_BIAS;
`else
    assign rsum = sum;
`endif

    // Taking the upper bits is the arithmetic shift; the top DATA_W bits always fit the result.
    assign result      = rsum[ACC_W-1:LOG2_DECIM];
    assign unused_lsbs = ^rsum[LOG2_DECIM-1:0];

    assign last      = in_valid && (cnt == LOG2_DECIM'(DECIM - 1));
    assign push      = last;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = $signed(head);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            acc      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else if (in_valid) begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    ddfs_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clr    (clr),
        .push   (push),
        .wdata  (result),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );

endmodule
